reg_access_arbiter: RTL and testbench

REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

---
 rtl/reg_access_arbiter_pkg.sv | 14 +
 rtl/reg_access_arbiter_if.sv | 32 +++
 rtl/reg_access_arbiter_rr_arbiter2.sv | 12 +
 rtl/reg_access_arbiter.sv | 96 +++++++++
 tb/tb_reg_access_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/reg_access_arbiter_pkg.sv
// Shared definitions for the two-requester register access arbiter:
// FSM state encoding and default data width.
package reg_access_arbiter_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/reg_access_arbiter_if.sv
// Requester handshake plus shared-register bus of the access arbiter.
// slave = arbiter side, master = requesters and the register itself.
interface reg_access_arbiter_if
  import reg_access_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic             Req0;
  logic             Req1;
  logic             Wr0;
  logic             Wr1;
  logic [WIDTH-1:0] WData0;
  logic [WIDTH-1:0] WData1;
  logic             Gnt0;
  logic             Gnt1;
  logic [WIDTH-1:0] RData;
  logic             Busy;
  logic             Ewr;
  logic             Edy;
  logic [WIDTH-1:0] RegData;
  logic [WIDTH-1:0] RegOut;

  modport slave (
    input  Req0, Req1, Wr0, Wr1, WData0, WData1, RegOut,
    output Gnt0, Gnt1, RData, Busy, Ewr, Edy, RegData
  );

  modport master (
    output Req0, Req1, Wr0, Wr1, WData0, WData1, RegOut,
    input  Gnt0, Gnt1, RData, Busy, Ewr, Edy, RegData
  );
endinterface

// File: rtl/reg_access_arbiter_rr_arbiter2.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes
// to the requester that was not served last.
module rr_arbiter2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_id,
  output logic o_vld
);
  assign o_vld = i_req0 | i_req1;
  assign o_id  = (i_req0 & i_req1) ? ~i_last : i_req1;
endmodule

// File: rtl/reg_access_arbiter.sv
// Serialises read/write accesses from two requesters onto one shared
// register with strobes that are all flop-driven.
module reg_access_arbiter
  import reg_access_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                Clock,
  input  logic                Reset,
  reg_access_arbiter_if.slave bus
);

  state_t           r_state;
  state_t           w_next;
  logic             r_last;
  logic             r_id;
  logic             r_ewr;
  logic             r_edy;
  logic             r_gnt0;
  logic             r_gnt1;
  logic [WIDTH-1:0] r_regdata;
  logic [WIDTH-1:0] r_rdata;

  logic             w_win_id;
  logic             w_win_vld;
  logic             w_take;
  logic             w_sel_wr;
  logic [WIDTH-1:0] w_sel_data;

  rr_arbiter2 u_rr (
    .i_req0 (bus.Req0),
    .i_req1 (bus.Req1),
    .i_last (r_last),
    .o_id   (w_win_id),
    .o_vld  (w_win_vld)
  );

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_take     = 1'b0;
    w_sel_wr   = w_win_id ? bus.Wr1 : bus.Wr0;
    w_sel_data = w_win_id ? bus.WData1 : bus.WData0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_take = 1'b1;
          w_next = w_sel_wr ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: w_next = ST_DONE;
      ST_READ:  w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Strobes and grants are registered from the next state so they line up
  // with the state they belong to without any decode glitches.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_last    <= 1'b1;
      r_id      <= 1'b0;
      r_ewr     <= 1'b1;
      r_edy     <= 1'b1;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_regdata <= '0;
      r_rdata   <= '0;
    end else begin
      r_ewr  <= (w_next != ST_WRITE);
      r_edy  <= (w_next != ST_READ);
      r_gnt0 <= (w_next == ST_DONE) && !r_id;
      r_gnt1 <= (w_next == ST_DONE) &&  r_id;
      if (w_take) begin
        r_last <= w_win_id;
        r_id   <= w_win_id;
        if (w_sel_wr) r_regdata <= w_sel_data;
      end
      if (r_state == ST_READ) r_rdata <= bus.RegOut;
    end
  end

  assign bus.Busy    = (r_state != ST_IDLE);
  assign bus.Ewr     = r_ewr;
  assign bus.Edy     = r_edy;
  assign bus.Gnt0    = r_gnt0;
  assign bus.Gnt1    = r_gnt1;
  assign bus.RegData = r_regdata;
  assign bus.RData   = r_rdata;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Scoreboard bench for reg_access_arbiter with a behavioural shared register.
module tb_reg_access_arbiter;
  import reg_access_arbiter_pkg::*;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  reg_access_arbiter_if #(.WIDTH(8)) bus ();

  reg_access_arbiter #(.WIDTH(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // Shared register: samples on the falling edge while Ewr is low,
  // drives its contents only while Edy is low.
  logic [7:0] reg_q = 8'h00;
  always @(negedge Clock) if (!bus.Ewr) reg_q <= bus.RegData;
  assign bus.RegOut = bus.Edy ? 8'h00 : reg_q;

  typedef struct {
    int         id;
    bit         wr;
    logic [7:0] val;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit prev_ewr_low = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every grant pulse and checks strobes.
  always @(negedge Clock) begin
    if (!Reset) begin
      exp_t e;
      check("ewr_edy_exclusive", {31'd0, (!bus.Ewr && !bus.Edy)}, 32'd0);
      if (!bus.Ewr) check("ewr_single_cycle", {31'd0, prev_ewr_low}, 32'd0);
      prev_ewr_low = !bus.Ewr;
      if (bus.Gnt0 || bus.Gnt1) begin
        check("gnt_onehot", {31'd0, (bus.Gnt0 && bus.Gnt1)}, 32'd0);
        if (q.size() == 0) begin
          check("unexpected_gnt", {30'd0, bus.Gnt1, bus.Gnt0}, 32'd0);
        end else begin
          e = q.pop_front();
          check("gnt_id", {31'd0, bus.Gnt1}, e.id);
          if (e.wr) check("reg_contents", {24'd0, reg_q}, {24'd0, e.val});
          else      check("rdata", {24'd0, bus.RData}, {24'd0, e.val});
        end
      end
    end else begin
      prev_ewr_low = 1'b0;
    end
  end

  task automatic set_req(input int id, input bit r, input bit wr, input logic [7:0] d);
    if (id == 0) begin bus.Req0 = r; bus.Wr0 = wr; bus.WData0 = d; end
    else         begin bus.Req1 = r; bus.Wr1 = wr; bus.WData1 = d; end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Called just after an edge with the DUT idle; d_after replaces the
  // write data once the request has been selected.
  task automatic issue(input int id, input bit wr, input logic [7:0] d,
                       input logic [7:0] d_after, input logic [7:0] exp_val);
    exp_t e;
    e.id = id; e.wr = wr; e.val = exp_val;
    q.push_back(e);
    set_req(id, 1'b1, wr, d);
    tick();
    set_req(id, 1'b1, wr, d_after);
    check("busy_active", {31'd0, bus.Busy}, 32'd1);
    check("ewr_in_op", {31'd0, bus.Ewr}, {31'd0, !wr});
    check("edy_in_op", {31'd0, bus.Edy}, {31'd0, wr});
    check("gnt_early", {30'd0, bus.Gnt1, bus.Gnt0}, 32'd0);
    if (wr) check("regdata", {24'd0, bus.RegData}, {24'd0, d});
    tick();
    check("gnt_latency", {31'd0, (id == 0) ? bus.Gnt0 : bus.Gnt1}, 32'd1);
    check("strobes_done", {30'd0, bus.Ewr, bus.Edy}, 32'd3);
    set_req(id, 1'b0, wr, d_after);
    tick();
    check("busy_idle", {31'd0, bus.Busy}, 32'd0);
  endtask

  initial begin
    int last_gc;
    int waited;
    bus.Req0 = 0; bus.Req1 = 0; bus.Wr0 = 0; bus.Wr1 = 0;
    bus.WData0 = 8'h00; bus.WData1 = 8'h00;

    // Reset state
    repeat (3) tick();
    check("rst_busy",    {31'd0, bus.Busy}, 32'd0);
    check("rst_ewr_edy", {30'd0, bus.Ewr, bus.Edy}, 32'd3);
    check("rst_gnt",     {30'd0, bus.Gnt1, bus.Gnt0}, 32'd0);
    check("rst_rdata",   {24'd0, bus.RData}, 32'd0);
    check("rst_regdata", {24'd0, bus.RegData}, 32'd0);
    Reset = 1'b0;
    tick();

    // Write A5 from requester 0, read it back from requester 1
    issue(0, 1'b1, 8'hA5, 8'hA5, 8'hA5);
    issue(1, 1'b0, 8'h00, 8'h00, 8'hA5);
    check("rdata_held", {24'd0, bus.RData}, 32'hA5);

    // Both requesters held: alternating grants, one every three cycles
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.id = k % 2; e.wr = 1'b1; e.val = (k % 2 == 0) ? 8'h11 : 8'h22;
      q.push_back(e);
    end
    set_req(0, 1'b1, 1'b1, 8'h11);
    set_req(1, 1'b1, 1'b1, 8'h22);
    last_gc = 0;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      do begin
        tick();
        waited++;
      end while (!(bus.Gnt0 || bus.Gnt1) && waited < 10);
      if (!(bus.Gnt0 || bus.Gnt1)) check("tie_gnt_timeout", 32'd0, 32'd1);
      if (k == 0) check("tie_first_latency", waited, 32'd2);
      else        check("tie_period", cyc - last_gc, 32'd3);
      last_gc = cyc;
    end
    set_req(0, 1'b0, 1'b1, 8'h11);
    set_req(1, 1'b0, 1'b1, 8'h22);
    tick();
    tick();
    check("tie_idle", {31'd0, bus.Busy}, 32'd0);

    // Request that drops before selection is ignored
    q.push_back('{id: 0, wr: 1'b1, val: 8'h77});
    set_req(0, 1'b1, 1'b1, 8'h77);
    tick();
    set_req(1, 1'b1, 1'b0, 8'h00);
    tick();
    set_req(0, 1'b0, 1'b1, 8'h77);
    set_req(1, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    check("dropped_req_ignored", {31'd0, bus.Busy}, 32'd0);

    // Reset during WRITE aborts with no grant
    set_req(0, 1'b1, 1'b1, 8'h5A);
    tick();
    check("abort_in_write", {31'd0, bus.Ewr}, 32'd0);
    Reset = 1'b1;
    set_req(0, 1'b0, 1'b1, 8'h5A);
    tick();
    check("abort_busy",    {31'd0, bus.Busy}, 32'd0);
    check("abort_ewr_edy", {30'd0, bus.Ewr, bus.Edy}, 32'd3);
    check("abort_gnt",     {30'd0, bus.Gnt1, bus.Gnt0}, 32'd0);
    check("abort_rdata",   {24'd0, bus.RData}, 32'd0);
    Reset = 1'b0;
    repeat (3) tick();

    // Write data changed after selection must not leak into the register
    issue(0, 1'b1, 8'h3C, 8'hFF, 8'h3C);
    issue(0, 1'b0, 8'h00, 8'h00, 8'h3C);

    repeat (3) tick();
    check("scoreboard_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
